mod_codec_init_sequencer: RTL and testbench
===========================================

// Module: mod_codec_init_sequencer
// PURPOSE
// - Boots the WM8731 codec: after reset it walks a fixed table of register writes and issues each one
//   to the I2C master (mod_i2c_master, 200 kHz domain) over a 4-phase req/ack handshake.
// - Retries faulted writes, flags completion or error, and re-runs on request.
// - Sits in mod_fpgaudio between the top level and u_i2c_driver. Replaces the hard-wired single write.
// PARAMETERS
// - SETTLE_CYCLES   50_000   i_clk cycles idle after reset before the first write (1 ms at 50 MHz)
// - TIMEOUT_CYCLES  200_000  max i_clk cycles waiting for any ack edge before the attempt counts as faulted
// - MAX_RETRIES     3        extra attempts per entry after the first; 0 = no retry
// PORTS
// - i_clk            in   1   system clock; all logic in this block is synchronous to it
// - i_rst            in   1   synchronous, active-high reset
// - i_start          in   1   re-run request; honoured only in DONE or ERROR
// - o_i2c_req        out  1   request level to the I2C master; held high until the ack is seen
// - o_i2c_addr       out  7   device address, constant CODEC_I2C_ADDR = 7'b0011010
// - o_i2c_register   out  7   register of the current entry; stable while o_i2c_req is high
// - o_i2c_data       out  9   data of the current entry; stable while o_i2c_req is high
// - i_i2c_ack        in   1   master's completion level (async); 2-flop synchronised internally
// - i_i2c_fault      in   4   master's fault code; 4'h0 = success; valid while ack is high
// - o_busy           out  1   high from leaving reset until DONE or ERROR
// - o_done           out  1   all entries written successfully; held until re-run or reset
// - o_error          out  1   an entry exhausted its retries; held until re-run or reset
// - o_index          out  4   index of the entry currently or last attempted
// - o_fault_code     out  4   last nonzero fault seen; 4'hE = timeout; 4'h0 if none
// BEHAVIOUR
// - Reset values: o_i2c_req=0, o_busy=1, o_done=0, o_error=0, o_index=0, o_fault_code=0. Reset enters SETTLE.
// - Synchronised versions of i_i2c_ack and i_i2c_fault are called ack_s and fault_s below.
// - Reset asserted in any state aborts mid-transfer with the same reset values; req drops in the next cycle.
// - SETTLE: count SETTLE_CYCLES, then go to ISSUE with index 0 and retries 0.
// - ISSUE: 1 cycle; present table[index] on register/data; set o_i2c_req=1; go to WAIT_ACK.
// - WAIT_ACK: wait for ack_s=1. On that cycle sample fault_s, drop o_i2c_req the next cycle, go to RELEASE.
//   - If the timeout counter reaches TIMEOUT_CYCLES first, record fault 4'hE, drop req, go to RELEASE.
// - RELEASE: wait for ack_s=0; this wait is also bounded by TIMEOUT_CYCLES, and on expiry go to ERROR with 4'hE.
//   - Fault 0: if index == N_ENTRIES-1 go to DONE, else index+1 and go to ISSUE.
//   - Fault nonzero or timeout: latch o_fault_code.
//     - retries < MAX_RETRIES: retries+1, re-ISSUE the same index.
//     - Otherwise go to ERROR; o_index keeps the failing entry.
// - Retries reset to 0 on each index advance. The timeout counter clears on every state entry.
// - DONE: o_done=1, o_busy=0. ERROR: o_error=1, o_busy=0.
//   - In either state, i_start=1 clears done, error and fault, zeroes index, and goes to ISSUE (no SETTLE).
// - i_start outside DONE/ERROR is ignored.
// - Register/data are registered outputs that change only in ISSUE; never while req=1.
// - The first request goes out exactly SETTLE_CYCLES+1 cycles after reset deasserts.
// - ack_s lags the raw ack by 2 cycles. A raw ack already high in ISSUE is not an error; RELEASE handles it.
// STRUCTURE
// - pkg_codec: codec_write_t = struct {logic [6:0] register; logic [8:0] data;}, CODEC_I2C_ADDR, N_ENTRIES=11.
// - pkg_codec: CODEC_INIT_TABLE, the constant array, in order:
//   - R15=000 (reset), R6=010, R0=017, R1=017, R2=079, R3=079
//   - R4=012, R5=000, R7=002, R8=000, R9=001
// - pkg_codec: FAULT_TIMEOUT = 4'hE; state enum {SETTLE, ISSUE, WAIT_ACK, RELEASE, DONE, ERROR}.
// - Sub-module mod_sync_2ff (parameterised width) synchronises {i_i2c_ack, i_i2c_fault}.
// TESTING (SETTLE_CYCLES=16, TIMEOUT_CYCLES=64 in the bench; model master acks 20 cycles after req)
// - Clean boot: release reset, model acks with fault 0.
//   -> 11 req pulses with register/data matching the table in order; o_done=1; o_busy=0; o_fault_code=0.
// - Single fault: fault=4'h3 on entry 4's first attempt only.
//   -> entry 4 is re-issued once; o_done=1; o_fault_code=3; 12 req pulses in total.
// - Persistent fault: entry 2 always returns 4'h5.
//   -> exactly 4 attempts on index 2; o_error=1; o_index=2; o_fault_code=5; no req to index 3.
// - Timeout: model never acks entry 0.
//   -> each attempt drops req after 64 cycles; 4 attempts; o_error=1; o_fault_code=4'hE.
// - Re-run: pulse i_start in DONE.
//   -> ISSUE next cycle with no settle; index 0 re-sent; o_done low until the rerun completes.
//   - i_start pulsed mid-sequence has no effect.
// - Reset mid-transfer: assert i_rst while req=1 on entry 5.
//   -> next cycle req=0, o_index=0, outputs at reset values; after SETTLE the sequence restarts at R15.

Source files
------------

// File: rtl/pkg_codec.sv
// rtl/pkg_codec.sv - shared types, constants and boot table for the WM8731 init sequencer
package pkg_codec;

  typedef struct packed {
    logic [6:0] register;
    logic [8:0] data;
  } codec_write_t;

  localparam logic [6:0] CODEC_I2C_ADDR = 7'b0011010;
  localparam int         N_ENTRIES      = 11;
  localparam logic [3:0] FAULT_TIMEOUT  = 4'hE;

  typedef enum logic [2:0] {
    SETTLE,
    ISSUE,
    WAIT_ACK,
    RELEASE,
    DONE,
    ERROR
  } state_t;

  // Reset first, then power-up, line-in, headphone, path, sampling and activate last.
  localparam codec_write_t CODEC_INIT_TABLE [N_ENTRIES] = '{
    '{7'd15, 9'h000},
    '{7'd6,  9'h010},
    '{7'd0,  9'h017},
    '{7'd1,  9'h017},
    '{7'd2,  9'h079},
    '{7'd3,  9'h079},
    '{7'd4,  9'h012},
    '{7'd5,  9'h000},
    '{7'd7,  9'h002},
    '{7'd8,  9'h000},
    '{7'd9,  9'h001}
  };

endpackage

// File: rtl/mod_sync_2ff.sv
// rtl/mod_sync_2ff.sv - two-flop synchroniser for a bus of quasi-static levels
module mod_sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/mod_codec_init_sequencer.sv
// rtl/mod_codec_init_sequencer.sv - walks the codec boot table over a 4-phase req/ack I2C handshake
// with per-entry retry, timeout, done/error flags and re-run on request.
module mod_codec_init_sequencer
  import pkg_codec::*;
#(
  parameter int SETTLE_CYCLES  = 50_000,
  parameter int TIMEOUT_CYCLES = 200_000,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  output logic       o_i2c_req,
  output logic [6:0] o_i2c_addr,
  output logic [6:0] o_i2c_register,
  output logic [8:0] o_i2c_data,
  input  logic       i_i2c_ack,
  input  logic [3:0] i_i2c_fault,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_error,
  output logic [3:0] o_index,
  output logic [3:0] o_fault_code
);

  localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RET_W   = $clog2(MAX_RETRIES + 2);

  logic [4:0] sync_bus;
  logic       ack_s;
  logic [3:0] fault_s;

  mod_sync_2ff #(.WIDTH(5)) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   ({i_i2c_ack, i_i2c_fault}),
    .o_q   (sync_bus)
  );

  assign ack_s   = sync_bus[4];
  assign fault_s = sync_bus[3:0];

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       index_q, index_d;
  logic [RET_W-1:0] retries_q, retries_d;
  logic [3:0]       fault_q, fault_d;
  logic [3:0]       fault_code_q, fault_code_d;
  logic             req_q, req_d;
  logic [6:0]       reg_q, reg_d;
  logic [8:0]       data_q, data_d;
  codec_write_t     entry;

  assign entry = CODEC_INIT_TABLE[index_q];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    index_d      = index_q;
    retries_d    = retries_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    req_d        = req_q;
    reg_d        = reg_q;
    data_d       = data_q;

    case (state_q)
      SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d   = ISSUE;
          index_d   = '0;
          retries_d = '0;
        end
      end
      ISSUE: begin
        reg_d   = entry.register;
        data_d  = entry.data;
        req_d   = 1'b1;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ack_s) begin
          fault_d = fault_s;
          req_d   = 1'b0;
          state_d = RELEASE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          fault_d = FAULT_TIMEOUT;
          req_d   = 1'b0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        // Wait for the master to finish its side of the handshake before deciding.
        if (!ack_s) begin
          if (fault_q == 4'h0) begin
            if (index_q == 4'(N_ENTRIES - 1)) begin
              state_d = DONE;
            end else begin
              index_d   = index_q + 4'd1;
              retries_d = '0;
              state_d   = ISSUE;
            end
          end else begin
            fault_code_d = fault_q;
            if (retries_q < RET_W'(MAX_RETRIES)) begin
              retries_d = retries_q + 1'b1;
              state_d   = ISSUE;
            end else begin
              state_d = ERROR;
            end
          end
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          fault_code_d = FAULT_TIMEOUT;
          state_d      = ERROR;
        end
      end
      DONE, ERROR: begin
        if (i_start) begin
          fault_code_d = '0;
          index_d      = '0;
          retries_d    = '0;
          state_d      = ISSUE;
        end
      end
      default: state_d = SETTLE;
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= SETTLE;
      cnt_q        <= '0;
      index_q      <= '0;
      retries_q    <= '0;
      fault_q      <= '0;
      fault_code_q <= '0;
      req_q        <= 1'b0;
      reg_q        <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      index_q      <= index_d;
      retries_q    <= retries_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
      req_q        <= req_d;
      reg_q        <= reg_d;
      data_q       <= data_d;
    end
  end

  assign o_i2c_req      = req_q;
  assign o_i2c_addr     = CODEC_I2C_ADDR;
  assign o_i2c_register = reg_q;
  assign o_i2c_data     = data_q;
  assign o_busy         = (state_q != DONE) && (state_q != ERROR);
  assign o_done         = (state_q == DONE);
  assign o_error        = (state_q == ERROR);
  assign o_index        = index_q;
  assign o_fault_code   = fault_code_q;

endmodule

// File: tb/tb_mod_codec_init_sequencer.sv
// tb/tb_mod_codec_init_sequencer.sv - directed bench for the codec init sequencer
module tb_mod_codec_init_sequencer;

  localparam int SETTLE    = 16;
  localparam int TIMEOUT   = 64;
  localparam int ACK_DELAY = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       req;
  logic [6:0] addr;
  logic [6:0] wreg;
  logic [8:0] wdata;
  logic       ack = 1'b0;
  logic [3:0] fault = 4'h0;
  logic       busy, done, error;
  logic [3:0] index, fault_code;

  always #5 clk = ~clk;

  mod_codec_init_sequencer #(
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TIMEOUT),
    .MAX_RETRIES    (3)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .o_i2c_req      (req),
    .o_i2c_addr     (addr),
    .o_i2c_register (wreg),
    .o_i2c_data     (wdata),
    .i_i2c_ack      (ack),
    .i_i2c_fault    (fault),
    .o_busy         (busy),
    .o_done         (done),
    .o_error        (error),
    .o_index        (index),
    .o_fault_code   (fault_code)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [15:0] exp_tab [0:10] = '{
    {7'd15, 9'h000}, {7'd6, 9'h010}, {7'd0, 9'h017}, {7'd1, 9'h017},
    {7'd2, 9'h079},  {7'd3, 9'h079}, {7'd4, 9'h012}, {7'd5, 9'h000},
    {7'd7, 9'h002},  {7'd8, 9'h000}, {7'd9, 9'h001}
  };

  // Master model configuration and transaction log.
  int          fault_idx = -1;
  int          fault_val = 0;
  bit          fault_once = 1'b0;
  int          mute_idx = -1;
  int          n_req = 0;
  logic [15:0] log_wr [0:31];
  int          log_ix [0:31];
  int          att [0:15];
  int          stable_err = 0;
  int          cur_idx = 0, wait_cnt = 0, cur_len = 0, last_len = 0;
  logic        req_prev = 1'b0;
  logic [15:0] held = '0;

  always @(negedge clk) begin
    if (req) begin
      if (!req_prev) begin
        cur_idx = int'(index);
        att[cur_idx]++;
        if (n_req < 32) begin
          log_wr[n_req] = {wreg, wdata};
          log_ix[n_req] = cur_idx;
        end
        n_req++;
        held     = {wreg, wdata};
        wait_cnt = 0;
        cur_len  = 0;
      end else if ({wreg, wdata} != held) begin
        stable_err++;
      end
      cur_len++;
      last_len = cur_len;
      if (!ack) begin
        wait_cnt++;
        if (wait_cnt == ACK_DELAY && cur_idx != mute_idx) begin
          ack = 1'b1;
          if (cur_idx == fault_idx && (!fault_once || att[cur_idx] == 1))
            fault = fault_val[3:0];
          else
            fault = 4'h0;
        end
      end
    end else begin
      ack   = 1'b0;
      fault = 4'h0;
    end
    req_prev = req;
  end

  task automatic clear_log();
    n_req      = 0;
    stable_err = 0;
    for (int i = 0; i < 16; i++) att[i] = 0;
  endtask

  task automatic configure(input int f_idx, input int f_val, input bit once, input int m_idx);
    fault_idx  = f_idx;
    fault_val  = f_val;
    fault_once = once;
    mute_idx   = m_idx;
  endtask

  task automatic reset_and_release();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    clear_log();
    rst = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (done || error) begin
        ok = 1'b1;
        break;
      end
    end
    check_value(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    int lat;
    bit seen;

    // Reset values while reset is held.
    repeat (3) @(posedge clk);
    #1;
    check_value("rst_req", 32'(req), 32'd0);
    check_value("rst_busy", 32'(busy), 32'd1);
    check_value("rst_done", 32'(done), 32'd0);
    check_value("rst_error", 32'(error), 32'd0);
    check_value("rst_index", 32'(index), 32'd0);
    check_value("rst_fault", 32'(fault_code), 32'd0);
    check_value("addr", 32'(addr), 32'h1A);

    // Clean boot with first-request latency.
    configure(-1, 0, 1'b0, -1);
    @(negedge clk);
    clear_log();
    rst = 1'b0;
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (req) break;
    end
    check_value("first_req_latency", 32'(lat), 32'(SETTLE + 1));
    wait_end("clean_finish");
    check_value("clean_nreq", 32'(n_req), 32'd11);
    for (int i = 0; i < 11; i++)
      check_value($sformatf("clean_entry%0d", i), 32'(log_wr[i]), 32'(exp_tab[i]));
    check_value("clean_done", 32'(done), 32'd1);
    check_value("clean_busy", 32'(busy), 32'd0);
    check_value("clean_error", 32'(error), 32'd0);
    check_value("clean_fault", 32'(fault_code), 32'd0);
    check_value("clean_stable", 32'(stable_err), 32'd0);

    // Re-run from DONE: no settle, index 0 re-sent.
    clear_log();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    check_value("rerun_done_low", 32'(done), 32'd0);
    check_value("rerun_busy", 32'(busy), 32'd1);
    check_value("rerun_index", 32'(index), 32'd0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check_value("rerun_req", 32'(req), 32'd1);
    check_value("rerun_reg", 32'(wreg), 32'd15);
    // Start pulse mid-sequence must be ignored.
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (n_req >= 3) begin
        seen = 1'b1;
        break;
      end
    end
    check_value("rerun_reach3", 32'(seen), 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end("rerun_finish");
    check_value("rerun_nreq", 32'(n_req), 32'd11);
    check_value("rerun_first", 32'(log_wr[0]), 32'(exp_tab[0]));
    check_value("rerun_done", 32'(done), 32'd1);

    // Single fault on entry 4, first attempt only.
    configure(4, 3, 1'b1, -1);
    reset_and_release();
    wait_end("single_finish");
    check_value("single_nreq", 32'(n_req), 32'd12);
    check_value("single_att4", 32'(att[4]), 32'd2);
    check_value("single_reissue_idx", 32'(log_ix[5]), 32'd4);
    check_value("single_reissue_wr", 32'(log_wr[5]), 32'(exp_tab[4]));
    check_value("single_done", 32'(done), 32'd1);
    check_value("single_fault", 32'(fault_code), 32'd3);

    // Persistent fault on entry 2.
    configure(2, 5, 1'b0, -1);
    reset_and_release();
    wait_end("persist_finish");
    check_value("persist_att2", 32'(att[2]), 32'd4);
    check_value("persist_att3", 32'(att[3]), 32'd0);
    check_value("persist_nreq", 32'(n_req), 32'd6);
    check_value("persist_error", 32'(error), 32'd1);
    check_value("persist_done", 32'(done), 32'd0);
    check_value("persist_busy", 32'(busy), 32'd0);
    check_value("persist_index", 32'(index), 32'd2);
    check_value("persist_fault", 32'(fault_code), 32'd5);

    // Entry 0 never acknowledged.
    configure(-1, 0, 1'b0, 0);
    reset_and_release();
    wait_end("timeout_finish");
    check_value("timeout_att0", 32'(att[0]), 32'd4);
    check_value("timeout_nreq", 32'(n_req), 32'd4);
    check_value("timeout_req_len", 32'(last_len), 32'(TIMEOUT));
    check_value("timeout_error", 32'(error), 32'd1);
    check_value("timeout_fault", 32'(fault_code), 32'hE);

    // Reset while entry 5 is in flight.
    configure(-1, 0, 1'b0, -1);
    reset_and_release();
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (req && index == 4'd5) begin
        seen = 1'b1;
        break;
      end
    end
    check_value("midrst_reach5", 32'(seen), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_value("midrst_req", 32'(req), 32'd0);
    check_value("midrst_index", 32'(index), 32'd0);
    check_value("midrst_busy", 32'(busy), 32'd1);
    check_value("midrst_done", 32'(done), 32'd0);
    check_value("midrst_error", 32'(error), 32'd0);
    check_value("midrst_fault", 32'(fault_code), 32'd0);
    @(negedge clk);
    clear_log();
    rst = 1'b0;
    wait_end("midrst_finish");
    check_value("midrst_nreq", 32'(n_req), 32'd11);
    check_value("midrst_first", 32'(log_wr[0]), 32'(exp_tab[0]));
    check_value("midrst_done_final", 32'(done), 32'd1);
    check_value("midrst_stable", 32'(stable_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
